prim_esc_sender: RTL and testbench

- Transmit end of the differential escalation protocol. Drives the escalation pair esc_tx_o[1:0] toward the escalation receiver and checks the returned response pair esc_rx_i[1:0].
- Converts a level escalation request and a ping request into the wire protocol.
- Reports a successful ping handshake and any integrity or protocol failure. Sits in the alert handler, one instance per escalation severity.

---
 rtl/prim_esc_sender.sv | 177 +++++++++++++++++
 tb/tb_prim_esc_sender.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prim_esc_sender.sv
// prim_esc_sender: transmit end of the differential escalation protocol.
// Turns a level escalation request and a ping request into the esc_tx pair.
// It checks the returned esc_rx pair and reports ping success and integrity failures.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   ping_en_i      ping request, only sampled in Idle
//   esc_en_i       escalation request level, overrides ping
//   esc_tx_o[1:0]  registered differential pair toward the receiver ([1]=p, [0]=n)
//   esc_rx_i[1:0]  differential response pair from the receiver ([1]=p, [0]=n)
//   ping_ok_o      one-cycle registered pulse when a ping handshake completes correctly
//   integ_fail_o   combinational integrity/protocol failure indication
//
// Optional: define ESC_SENDER_STICKY_FAIL_EN to hold integ_fail_o high after
// the first failure until rst_i.

module prim_esc_sender #(
  parameter bit PingChk = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ping_en_i,
  input  logic       esc_en_i,
  output logic [1:0] esc_tx_o,
  input  logic [1:0] esc_rx_i,
  output logic       ping_ok_o,
  output logic       integ_fail_o
);

  localparam logic [1:0] TxOn  = 2'b10;
  localparam logic [1:0] TxOff = 2'b01;
  localparam logic [1:0] RxHi  = 2'b10;
  localparam logic [1:0] RxLo  = 2'b01;

  typedef enum logic [2:0] {
    Idle,
    Ping0,
    Ping1,
    Ping2,
    Ping3,
    EscStart,
    EscAct,
    EscEnd
  } state_e;

  state_e     state_q;
  logic [1:0] esc_tx_q;
  logic       ping_ok_q;
  // Set in Idle for the single cycle in which the ping pulse is on the wire.
  // The receiver answers one cycle later, and Ping0 checks that answer.
  logic       launch_q;
  logic       bad_q;
  logic       rx_p_q;

  logic [1:0] ping_exp_c;
  logic       is_ping_c;
  logic       ping_mis_c;
  logic       fail_c;

  // Expected ping response per state and the combinational failure decode.
  always_comb begin
    ping_exp_c = RxLo;
    is_ping_c  = 1'b0;
    unique case (state_q)
      Ping0, Ping2: begin
        ping_exp_c = RxHi;
        is_ping_c  = 1'b1;
      end
      Ping1, Ping3: begin
        ping_exp_c = RxLo;
        is_ping_c  = 1'b1;
      end
      default: ;
    endcase
    ping_mis_c = is_ping_c && (esc_rx_i != ping_exp_c);

    // The differential check applies in every state. 00 and 11 are both illegal.
    fail_c = (esc_rx_i[1] == esc_rx_i[0]);
    unique case (state_q)
      Idle: begin
        if (esc_rx_i != RxLo) fail_c = 1'b1;
      end
      Ping0, Ping1, Ping2, Ping3: begin
        if (PingChk && ping_mis_c) fail_c = 1'b1;
      end
      EscAct: begin
        // The receiver must toggle p on every active escalation cycle.
        if (esc_rx_i[1] == rx_p_q) fail_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Protocol FSM with registered wire and ping-ok outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      esc_tx_q  <= TxOff;
      ping_ok_q <= 1'b0;
      launch_q  <= 1'b0;
      bad_q     <= 1'b0;
      rx_p_q    <= 1'b0;
    end else begin
      rx_p_q    <= esc_rx_i[1];
      esc_tx_q  <= TxOff;
      ping_ok_q <= 1'b0;
      launch_q  <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (esc_en_i) begin
            state_q  <= EscStart;
            esc_tx_q <= TxOn;
          end else if (launch_q) begin
            state_q <= Ping0;
            bad_q   <= 1'b0;
          end else if (ping_en_i) begin
            esc_tx_q <= TxOn;
            launch_q <= 1'b1;
          end
        end
        Ping0, Ping1, Ping2: begin
          bad_q <= bad_q | ping_mis_c;
          if (esc_en_i) begin
            state_q  <= EscStart;
            esc_tx_q <= TxOn;
          end else begin
            state_q <= (state_q == Ping0) ? Ping1 :
                       (state_q == Ping1) ? Ping2 : Ping3;
          end
        end
        Ping3: begin
          bad_q <= bad_q | ping_mis_c;
          if (esc_en_i) begin
            state_q  <= EscStart;
            esc_tx_q <= TxOn;
          end else begin
            state_q   <= Idle;
            ping_ok_q <= !(bad_q || ping_mis_c);
          end
        end
        EscStart: begin
          state_q  <= EscAct;
          esc_tx_q <= TxOn;
        end
        EscAct: begin
          esc_tx_q <= esc_en_i ? TxOn : TxOff;
          if (!esc_en_i) state_q <= EscEnd;
        end
        EscEnd: begin
          state_q <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign esc_tx_o  = esc_tx_q;
  assign ping_ok_o = ping_ok_q;

`ifdef ESC_SENDER_STICKY_FAIL_EN
  logic sticky_q;

  // Remembers any failure until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= 1'b0;
    end else if (fail_c) begin
      sticky_q <= 1'b1;
    end
  end

  assign integ_fail_o = fail_c | sticky_q;
`else
  assign integ_fail_o = fail_c;
`endif

endmodule

// File: tb/tb_prim_esc_sender.sv
// Testbench for prim_esc_sender. It runs one instance with PingChk=1 and one with
// PingChk=0 on the same stimulus. Expected outputs are queued when a cycle is driven.
// They are popped and compared on the falling edge of that cycle.

module tb_prim_esc_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       ping_en;
  logic       esc_en;
  logic [1:0] rx;
  logic [1:0] tx;
  logic [1:0] tx_nc;
  logic       ok;
  logic       ok_nc;
  logic       fail;
  logic       fail_nc;

  always #5 clk = ~clk;

  prim_esc_sender #(.PingChk(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ping_en_i   (ping_en),
    .esc_en_i    (esc_en),
    .esc_tx_o    (tx),
    .esc_rx_i    (rx),
    .ping_ok_o   (ok),
    .integ_fail_o(fail)
  );

  prim_esc_sender #(.PingChk(1'b0)) dut_nc (
    .clk_i       (clk),
    .rst_i       (rst),
    .ping_en_i   (ping_en),
    .esc_en_i    (esc_en),
    .esc_tx_o    (tx_nc),
    .esc_rx_i    (rx),
    .ping_ok_o   (ok_nc),
    .integ_fail_o(fail_nc)
  );

  typedef struct packed {
    logic [1:0] tx;
    logic       ok;
    logic       fail;
    logic       fail_nc;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  cur;
  int    errs   = 0;
  int    checks = 0;
  int    cyc    = 0;
  string phase  = "init";
  logic  sticky_m    = 1'b0;
  logic  sticky_nc_m = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must show in that cycle.
  task automatic step(input logic r, input logic p, input logic e, input logic [1:0] rxv,
                      input logic [1:0] etx, input logic eok, input logic ef,
                      input logic efnc, input bit chk);
    exp_t x;
    @(posedge clk);
    #1;
    rst     = r;
    ping_en = p;
    esc_en  = e;
    rx      = rxv;
    cyc++;
    x.tx      = etx;
    x.ok      = eok;
    x.fail    = ef | sticky_m;
    x.fail_nc = efnc | sticky_nc_m;
    if (chk) exp_q.push_back(x);
`ifdef ESC_SENDER_STICKY_FAIL_EN
    sticky_m    = r ? 1'b0 : (sticky_m | ef);
    sticky_nc_m = r ? 1'b0 : (sticky_nc_m | efnc);
`endif
  endtask

  task automatic c(input logic p, input logic e, input logic [1:0] rxv,
                   input logic [1:0] etx, input logic eok, input logic ef, input logic efnc);
    step(1'b0, p, e, rxv, etx, eok, ef, efnc, 1'b1);
  endtask

  task automatic do_reset(input string name);
    phase = name;
    step(1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Scoreboard: compare the oldest queued expectation at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check_eq($sformatf("%s@%0d.tx", phase, cyc), 8'(tx), 8'(cur.tx));
      check_eq($sformatf("%s@%0d.tx_nc", phase, cyc), 8'(tx_nc), 8'(cur.tx));
      check_eq($sformatf("%s@%0d.ping_ok", phase, cyc), 8'(ok), 8'(cur.ok));
      check_eq($sformatf("%s@%0d.ping_ok_nc", phase, cyc), 8'(ok_nc), 8'(cur.ok));
      check_eq($sformatf("%s@%0d.integ_fail", phase, cyc), 8'(fail), 8'(cur.fail));
      check_eq($sformatf("%s@%0d.integ_fail_nc", phase, cyc), 8'(fail_nc), 8'(cur.fail_nc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    ping_en = 1'b0;
    esc_en  = 1'b0;
    rx      = 2'b01;

    do_reset("reset");

    // Good ping; a ping_en during the ping states is ignored.
    phase = "ping_ok";
    c(1, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b10, 0, 0, 0);
    c(0, 0, 2'b10, 2'b01, 0, 0, 0);
    c(1, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b10, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 1, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    // Ping with a wrong third response.
    phase = "ping_bad";
    c(1, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b10, 0, 0, 0);
    c(0, 0, 2'b10, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 1, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    do_reset("reset2");

    // Escalation for six request cycles with a toggling receiver.
    phase = "esc";
    c(0, 1, 2'b01, 2'b01, 0, 0, 0);
    c(0, 1, 2'b01, 2'b10, 0, 0, 0);
    c(0, 1, 2'b10, 2'b10, 0, 0, 0);
    c(0, 1, 2'b01, 2'b10, 0, 0, 0);
    c(0, 1, 2'b10, 2'b10, 0, 0, 0);
    c(0, 1, 2'b01, 2'b10, 0, 0, 0);
    c(0, 0, 2'b10, 2'b10, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    // Escalation with the receiver stuck at 10 for two EscAct cycles.
    phase = "esc_stuck";
    c(0, 1, 2'b01, 2'b01, 0, 0, 0);
    c(0, 1, 2'b01, 2'b10, 0, 0, 0);
    c(0, 1, 2'b10, 2'b10, 0, 0, 0);
    c(0, 1, 2'b10, 2'b10, 0, 1, 1);
    c(0, 1, 2'b01, 2'b10, 0, 0, 0);
    c(0, 1, 2'b10, 2'b10, 0, 0, 0);
    c(0, 0, 2'b01, 2'b10, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    do_reset("reset3");

    // Illegal and unexpected response codes in Idle.
    phase = "idle_rx";
    c(0, 0, 2'b00, 2'b01, 0, 1, 1);
    c(0, 0, 2'b11, 2'b01, 0, 1, 1);
    c(0, 0, 2'b10, 2'b01, 0, 1, 1);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    do_reset("reset4");

    // Simultaneous requests: escalation wins, and a one-cycle escalation.
    phase = "esc_1cyc";
    c(1, 1, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b10, 0, 0, 0);
    c(0, 0, 2'b10, 2'b10, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    // Ping aborted by escalation at T+2; toggle checking applies in EscAct.
    phase = "ping_abort";
    c(1, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b10, 0, 0, 0);
    c(0, 0, 2'b10, 2'b01, 0, 0, 0);
    c(0, 1, 2'b01, 2'b01, 0, 0, 0);
    c(0, 1, 2'b10, 2'b10, 0, 0, 0);
    c(0, 1, 2'b01, 2'b10, 0, 0, 0);
    c(0, 1, 2'b01, 2'b10, 0, 1, 1);
    c(0, 0, 2'b10, 2'b10, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    // Reset in the middle of a ping aborts it without a ping_ok pulse.
    phase = "ping_rst";
    c(1, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b10, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);
    c(0, 0, 2'b01, 2'b01, 0, 0, 0);

    @(negedge clk);
    #1;
    check_eq("drain", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
